fetch_stage: RTL

Instruction-fetch stage with its IF/ID pipeline register. It sits directly upstream of decode and the ID/EX register. It owns the PC and issues reads to a variable-latency instruction memory. It buffers a returned instruction while downstream is stalled, squashes in-flight fetches on redirect, and stops fetching after a HALT. It drives `fetch_stall`, which freezes the downstream pipeline registers.

---
 rtl/fetch_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, skid buffer, redirect squash and halt.
// Optional stall counter port stall_cnt is built when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        hazard_stall,
    input  logic        mem_stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr_out,
    output logic [15:0] pc2_out,
    output logic        nop_out,
    output logic        fetch_stall
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_SQUASH,
        S_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        nop_q, nop_d;
    logic [15:0] buf_q, buf_d;

    logic        hold;
    logic        read_active;
    logic [15:0] pc_plus2;

    assign hold     = hazard_stall | mem_stall;
    assign pc_plus2 = pc_q + 16'd2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc2_q   <= 16'h0000;
            nop_q   <= 1'b1;
            buf_q   <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            nop_q   <= nop_d;
            buf_q   <= buf_d;
        end
    end

    // Redirect overrides everything; otherwise each state decides what IF/ID and PC take.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc2_d   = pc2_q;
        nop_d   = nop_q;
        buf_d   = buf_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            instr_d = NOP_INSTR;
            nop_d   = 1'b1;
            buf_d   = NOP_INSTR;
            state_d = (read_active && !imem_done) ? S_SQUASH : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH, S_WAIT: begin
                    if (imem_done) begin
                        if (!hold) begin
                            instr_d = imem_data;
                            pc2_d   = pc_plus2;
                            nop_d   = 1'b0;
                            pc_d    = pc_plus2;
                            state_d = (imem_data[15:11] == 5'b00000) ? S_HALTED : S_FETCH;
                        end else begin
                            buf_d   = imem_data;
                            state_d = S_HOLD;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!hold) begin
                        instr_d = buf_q;
                        pc2_d   = pc_plus2;
                        nop_d   = 1'b0;
                        pc_d    = pc_plus2;
                        state_d = (buf_q[15:11] == 5'b00000) ? S_HALTED : S_FETCH;
                    end
                end
                S_SQUASH: begin
                    if (imem_done) begin
                        state_d = S_FETCH;
                    end
                end
                S_HALTED: begin
                    if (!hold) begin
                        instr_d = NOP_INSTR;
                        nop_d   = 1'b1;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // Read request is suppressed while reset is held so the memory sees no request.
    always_comb begin
        read_active = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_SQUASH);
        imem_rd     = read_active & rst;
        fetch_stall = imem_rd & ~imem_done & ~redirect;
        imem_addr   = pc_q;
        instr_out   = instr_q;
        pc2_out     = pc2_q;
        nop_out     = nop_q;
    end

`ifdef FETCH_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (fetch_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
